// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial subtraction sequencer around a 1-bit full-subtractor cell
//
// Computes D = A - B - Bin one bit per clock, LSB first, with the borrow
// carried between bits in a register.
//
// Parameters:
//   WIDTH   operand/result width, 1..64
//
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous reset, active-high
//   start   request, sampled only in IDLE
//   A, B    minuend / subtrahend, captured on the accepted start edge
//   Bin     borrow-in, captured on the accepted start edge
//   busy    high while bits are being processed
//   done    one-cycle pulse, D/Bout valid
//   D       registered difference, held until the next result
//   Bout    registered final borrow-out, held with D
//   Ovf     (only with SERIAL_SUB_OVF_EN) signed overflow, registered with D
//
// Optional feature macro: SERIAL_SUB_OVF_EN

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic             w_d_bit;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
`endif

    // Full-subtractor cell on the current LSBs
    assign w_d_bit   = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
    assign w_br_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    // Result fills from the MSB down so that after WIDTH shifts bit 0 holds the LSB
    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_d_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            D       <= '0;
            Bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            Ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_br    <= Bin;
                        r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= B[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_br   <= w_br_next;
                    r_res  <= w_res_next;
                    if (w_last) begin
                        D    <= w_res_next;
                        Bout <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // Operands of differing sign and a result whose sign differs from A
                        Ovf  <= (r_a_msb ^ r_b_msb) & (w_res_next[WIDTH-1] ^ r_a_msb);
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl

module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, d8;
    logic       start1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, d1;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf1;
`endif

    serial_sub_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
        , .Ovf(ovf8)
`endif
    );

    serial_sub_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Bin(bin1),
        .busy(busy1), .done(done1), .D(d1), .Bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
        , .Ovf(ovf1)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic bin;
        logic d;
        logic bout;
    } vec1_t;

    vec8_t v8[9];
    vec1_t v1[8];

    task automatic run8(input string name, input vec8_t v);
        int lat = 0;
        int nbusy = 0;
        @(negedge clk);
        a8 = v.a; b8 = v.b; bin8 = v.bin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (busy8) nbusy++;
            if (done8) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chk({name, " latency"}, lat, 9);
        chk({name, " busy_cycles"}, nbusy, 8);
        chk({name, " D"}, d8, v.d);
        chk({name, " Bout"}, bout8, v.bout);
`ifdef SERIAL_SUB_OVF_EN
        chk({name, " Ovf"}, ovf8, v.ovf);
`endif
        @(negedge clk);
        chk({name, " done_one_cycle"}, done8, 0);
    endtask

    task automatic run1(input string name, input vec1_t v);
        int lat = 0;
        @(negedge clk);
        a1 = v.a; b1 = v.b; bin1 = v.bin; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (done1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chk({name, " latency"}, lat, 2);
        chk({name, " D"}, d1, v.d);
        chk({name, " Bout"}, bout1, v.bout);
    endtask

    initial begin
        int ndone;
        int first_done;
        int second_done;

        v8[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        v8[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        v8[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        v8[3] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
        v8[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        v8[5] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
        v8[6] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        v8[7] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        v8[8] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};

        v1[0] = '{0, 0, 0, 0, 0};
        v1[1] = '{0, 0, 1, 1, 1};
        v1[2] = '{0, 1, 0, 1, 1};
        v1[3] = '{0, 1, 1, 0, 1};
        v1[4] = '{1, 0, 0, 1, 0};
        v1[5] = '{1, 0, 1, 0, 0};
        v1[6] = '{1, 1, 0, 0, 0};
        v1[7] = '{1, 1, 1, 1, 1};

        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        #12;
        chk("reset busy", busy8, 0);
        chk("reset done", done8, 0);
        chk("reset D", d8, 0);
        chk("reset Bout", bout8, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run8($sformatf("w8_vec%0d", i), v8[i]);
        end

        // Result must hold through idle cycles
        repeat (3) @(negedge clk);
        chk("hold D", d8, 8'h0F);
        chk("hold Bout", bout8, 0);

        for (int i = 0; i < 8; i++) begin
            run1($sformatf("w1_vec%0d", i), v1[i]);
        end

        // Start during RUN is ignored
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; bin8 = 0; start8 = 1;
        @(negedge clk);
        start8 = 0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1;
        @(negedge clk);
        start8 = 0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        chk("ignore_start done_count", ndone, 1);
        chk("ignore_start D", d8, 8'h55);
        chk("ignore_start Bout", bout8, 0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; start8 = 1;
        @(negedge clk);
        start8 = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst busy", busy8, 0);
        chk("midrun_rst D", d8, 0);
        chk("midrun_rst Bout", bout8, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        chk("midrun_rst no_done", ndone, 0);
        run8("after_rst", v8[8]);

        // start held high: one result every WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h03; bin8 = 0; start8 = 1;
        first_done = 0;
        second_done = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) begin
                if (first_done == 0) first_done = i;
                else if (second_done == 0) second_done = i;
            end
        end
        start8 = 0;
        chk("b2b first_seen", (first_done != 0), 1);
        chk("b2b spacing", second_done - first_done, 10);
        chk("b2b D", d8, 8'h02);
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
